// File: rtl/dual_slope_pkg.sv
// Shared types and defaults for the dual-slope ADC sequencer.
package dual_slope_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AZ,
    S_GAP1,
    S_INT,
    S_GAP2,
    S_DEINT,
    S_DONE
  } state_t;

  localparam int DEF_CNT_W      = 12;
  localparam int DEF_INT_CYCLES = 4096;
  localparam int DEF_AZ_CYCLES  = 16;

  // Channel-select width; never below one bit so a single-input build still has a port.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dual_slope_cnt.sv
// Loadable up-counter with clear, enable and terminal-count flag.
// Clear wins over load, load wins over enable.
module dual_slope_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC conversion sequencer: auto-zero, fixed-time integration,
// reference de-integration with an internal result counter and overflow flag.
// Optional chained scanning across channels: define DUAL_SLOPE_AUTOSCAN_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start, zeroing switch closed
// S_AZ    | auto-zero, zeroing switch closed for AZ_CYCLES
// S_GAP1  | all switches open, one cycle
// S_INT   | selected input switch closed for INT_CYCLES
// S_GAP2  | all switches open, one cycle
// S_DEINT | reference switch closed, result counter running
// S_DONE  | result valid for one cycle, zeroing switch closed
module dual_slope_ctrl
  import dual_slope_pkg::*;
#(
  parameter int  NUM_CH     = 4,
  parameter int  CNT_W      = DEF_CNT_W,
  parameter int  INT_CYCLES = DEF_INT_CYCLES,
  parameter int  AZ_CYCLES  = DEF_AZ_CYCLES,
  localparam int SEL_W      = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              iniciar,
  input  logic [SEL_W-1:0]  ch_sel,
  input  logic              vint_z,
  output logic [NUM_CH-1:0] ch_vm,
  output logic              ch_ref,
  output logic              ch_zr,
  output logic              busy,
  output logic [CNT_W-1:0]  result,
  output logic [SEL_W-1:0]  result_ch,
  output logic              valid,
  output logic              overflow
);

  localparam int PH_MAX = (INT_CYCLES > AZ_CYCLES) ? INT_CYCLES : AZ_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX) + 1;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   ch_q, ch_q_nxt;
  logic [NUM_CH-1:0]  vm_nxt;
  logic               zr_nxt, ref_nxt;
  logic               ch_ok;

  logic [PH_W-1:0]    ph_tc_val;
  logic [PH_W-1:0]    ph_cnt_unused;
  logic               ph_tc, ph_clr, ph_en;
  logic [CNT_W-1:0]   res_cnt;
  logic               res_tc, res_clr, res_en;

  assign ch_ok     = (int'(ch_sel) < NUM_CH);
  assign ph_tc_val = (state == S_INT) ? PH_W'(INT_CYCLES - 1) : PH_W'(AZ_CYCLES - 1);

  // Phase timer restarts from zero on every state change so each phase starts clean.
  assign ph_clr  = (state_nxt != state);
  assign ph_en   = (state == S_AZ) || (state == S_INT);
  // Result counter is held at zero outside de-integration and stops at all-ones.
  assign res_clr = (state != S_DEINT);
  assign res_en  = (state == S_DEINT) && !res_tc;

  dual_slope_cnt #(.W(PH_W)) u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (ph_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (ph_en),
    .tc_val   (ph_tc_val),
    .cnt      (ph_cnt_unused),
    .tc       (ph_tc)
  );

  dual_slope_cnt #(.W(CNT_W)) u_result (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (res_clr),
    .load     (1'b0),
    .load_val ('0),
    .en       (res_en),
    .tc_val   ({CNT_W{1'b1}}),
    .cnt      (res_cnt),
    .tc       (res_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state, channel latch and next switch pattern.
  always_comb begin
    state_nxt = state;
    ch_q_nxt  = ch_q;
    vm_nxt    = '0;
    case (state)
      S_IDLE: begin
        if (iniciar && ch_ok) begin
          state_nxt = S_AZ;
          ch_q_nxt  = ch_sel;
        end
      end
      S_AZ:    if (ph_tc) state_nxt = S_GAP1;
      S_GAP1:  state_nxt = S_INT;
      S_INT:   if (ph_tc) state_nxt = S_GAP2;
      S_GAP2:  state_nxt = S_DEINT;
      S_DEINT: if (vint_z || res_tc) state_nxt = S_DONE;
      S_DONE: begin
`ifdef DUAL_SLOPE_AUTOSCAN_EN
        if (iniciar) begin
          state_nxt = S_AZ;
          ch_q_nxt  = (int'(ch_q) == NUM_CH - 1) ? '0 : ch_q + 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
`else
        state_nxt = S_IDLE;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
    zr_nxt  = (state_nxt == S_IDLE) || (state_nxt == S_AZ) || (state_nxt == S_DONE);
    ref_nxt = (state_nxt == S_DEINT);
    if (state_nxt == S_INT) vm_nxt[ch_q_nxt] = 1'b1;
  end

  // Registered outputs, aligned with the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ch_zr     <= 1'b1;
      ch_vm     <= '0;
      ch_ref    <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      result    <= '0;
      result_ch <= '0;
      ch_q      <= '0;
    end else begin
      ch_zr  <= zr_nxt;
      ch_vm  <= vm_nxt;
      ch_ref <= ref_nxt;
      busy   <= (state_nxt != S_IDLE);
      valid  <= (state_nxt == S_DONE);
      ch_q   <= ch_q_nxt;
      if (state == S_DEINT && state_nxt == S_DONE) begin
        // A crossing on the terminal count still counts as a normal result.
        result   <= res_cnt;
        overflow <= !vint_z;
      end
      if (state_nxt == S_DONE) result_ch <= ch_q;
    end
  end

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Self-checking bench for dual_slope_ctrl: directed and randomized conversions
// checked cycle by cycle against phase lengths and expected results.
module tb_dual_slope_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int AZ     = 4;
  localparam int INTC   = 100;
  localparam int MAXCNT = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              iniciar = 1'b0;
  logic [1:0]        ch_sel = '0;
  logic              vint_z = 1'b0;
  logic [NUM_CH-1:0] ch_vm;
  logic              ch_ref, ch_zr, busy, valid, overflow;
  logic [CNT_W-1:0]  result;
  logic [1:0]        result_ch;

  int checks = 0;
  int errors = 0;

  dual_slope_ctrl #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .INT_CYCLES(INTC), .AZ_CYCLES(AZ)
  ) dut (
    .clk(clk), .reset_n(reset_n), .iniciar(iniciar), .ch_sel(ch_sel),
    .vint_z(vint_z), .ch_vm(ch_vm), .ch_ref(ch_ref), .ch_zr(ch_zr),
    .busy(busy), .result(result), .result_ch(result_ch), .valid(valid),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_sw();
    return 32'({ch_zr, ch_vm, ch_ref, busy, valid});
  endfunction

  // Expected switch/status bundle; vm < 0 means no input switch closed.
  function automatic logic [31:0] exp_sw(input int zr, input int vm, input int rf,
                                         input int bz, input int vl);
    logic [NUM_CH-1:0] v;
    v = '0;
    if (vm >= 0) v[vm] = 1'b1;
    return 32'({1'(zr), v, 1'(rf), 1'(bz), 1'(vl)});
  endfunction

  task automatic noise(input bit en);
    if (en) begin
      iniciar = 1'($urandom_range(0, 1));
      vint_z  = 1'($urandom_range(0, 1));
      ch_sel  = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic start(input int ch);
    ch_sel  = 2'(ch);
    iniciar = 1'b1;
    vint_z  = 1'b0;
    step();
    iniciar = 1'b0;
  endtask

  // Runs from the first auto-zero cycle; k is the DEINT count at which the
  // comparator fires (k > MAXCNT means it never fires).
  task automatic conv_body(input int ch, input int k, input bit nz, input bit hold);
    int exp_res;
    int exp_ovf;
    exp_res = (k <= MAXCNT) ? k : MAXCNT;
    exp_ovf = (k > MAXCNT) ? 1 : 0;
    for (int i = 0; i < AZ; i++) begin
      chk("az", obs_sw(), exp_sw(1, -1, 0, 1, 0));
      noise(nz);
      step();
    end
    chk("gap1", obs_sw(), exp_sw(0, -1, 0, 1, 0));
    noise(nz);
    step();
    for (int i = 0; i < INTC; i++) begin
      chk("int", obs_sw(), exp_sw(0, ch, 0, 1, 0));
      noise(nz);
      step();
    end
    chk("gap2", obs_sw(), exp_sw(0, -1, 0, 1, 0));
    noise(nz);
    step();
    for (int j = 0; j <= MAXCNT; j++) begin
      chk("deint", obs_sw(), exp_sw(0, -1, 1, 1, 0));
      if (nz) iniciar = 1'($urandom_range(0, 1));
      vint_z = (j == k);
      step();
      if (j == k) break;
    end
    iniciar = hold;
    vint_z  = 1'b0;
    chk("done", obs_sw(), exp_sw(1, -1, 0, 1, 1));
    chk("result", 32'(result), 32'(exp_res));
    chk("result_ch", 32'(result_ch), 32'(ch));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    step();
    if (!hold) begin
      chk("idle", obs_sw(), exp_sw(1, -1, 0, 0, 0));
      chk("held_result", 32'(result), 32'(exp_res));
      chk("held_ovf", 32'(overflow), 32'(exp_ovf));
      step();
    end
  endtask

  initial begin
    int ch;
    int k;

    // Reset state
    reset_n = 1'b0;
    step();
    step();
    chk("rst_sw", obs_sw(), exp_sw(1, -1, 0, 0, 0));
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_result_ch", 32'(result_ch), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_idle", obs_sw(), exp_sw(1, -1, 0, 0, 0));
    end

    // Directed conversions: nominal, overflow, both-on-terminal, zero count
    start(2);
    conv_body(2, 37, 1'b0, 1'b0);
    start(1);
    conv_body(1, 1000, 1'b0, 1'b0);
    start(3);
    conv_body(3, MAXCNT, 1'b1, 1'b0);
    start(0);
    conv_body(0, 0, 1'b1, 1'b0);

    // Randomized conversions with start/comparator noise outside their windows
    for (int n = 0; n < 6; n++) begin
      ch = int'($urandom_range(0, NUM_CH - 1));
      k  = int'($urandom_range(0, MAXCNT + 45));
      start(ch);
      conv_body(ch, k, 1'b1, 1'b0);
    end

    // Reset during de-integration aborts without a valid pulse
    start(1);
    for (int i = 0; i < AZ + 1 + INTC + 1 + 10; i++) step();
    chk("pre_abort_deint", obs_sw(), exp_sw(0, -1, 1, 1, 0));
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("abort_sw", obs_sw(), exp_sw(1, -1, 0, 0, 0));
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("abort_idle", obs_sw(), exp_sw(1, -1, 0, 0, 0));
    end

`ifdef DUAL_SLOPE_AUTOSCAN_EN
    // Chained scan from channel 3 with start held high
    start(3);
    iniciar = 1'b1;
    conv_body(3, 20, 1'b0, 1'b1);
    ch_sel = 2'd2;
    conv_body(0, 300, 1'b0, 1'b1);
    conv_body(1, 5, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
